// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC round-robin scheduler.
// Contents:
//   - default engine widths and the X seed (gain-compensated 32000)
//   - angle constants for a 32-bit full circle
//   - tag_t: the {valid, requester id} pair tracked beside the engine
package cordic_pkg;

  localparam int CORDIC_WIDTH = 16;
  localparam int ANGLE_W      = 32;
  // round(32000 / 1.647): the engine gain brings this back to ~32000.
  localparam int XSEED        = 19429;

  localparam logic [ANGLE_W-1:0] DEG45 = 32'h2000_0000;
  localparam logic [ANGLE_W-1:0] DEG60 = 32'h2AAA_AAAA;
  localparam logic [ANGLE_W-1:0] DEG75 = 32'h3555_5555;
  localparam logic [ANGLE_W-1:0] DEG90 = 32'h4000_0000;

  // Wide enough for the largest supported requester count (8).
  localparam int ID_W = 3;

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : when low, no grant is made and the pointer holds
//   req        : per-requester request
//   grant      : one-hot grant, combinational from req, en and the pointer
// The grant goes to the first requester at or after the pointer (wrapping);
// after a grant to i the pointer moves to i+1 so i has lowest priority next.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] idx;
  logic          found;

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    idx      = '0;
    ptr_next = ptr;
    // Gating with rst_n keeps the grant low while reset is asserted,
    // not just from the first edge after it.
    if (en && rst_n) begin
      for (int k = 0; k < N; k++) begin
        idx = PW'((int'(ptr) + k) % N);
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
          ptr_next   = PW'((int'(idx) + 1) % N);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/cordic_rr_scheduler.sv
// Shares one pipelined CORDIC sin/cos engine among NREQ requesters.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   en                : issue enable; in-flight work drains when low
//   req_valid         : per-requester angle valid
//   req_angle         : packed angles, requester i at [i*AW +: AW]
//   req_ready         : one-hot grant (combinational)
//   cordic_x/y        : constant engine seed (XSEED, 0)
//   cordic_angle      : registered angle to the engine
//   cordic_cos/sin    : engine results
//   res_valid/id      : one-cycle result strobe and originating requester
//   res_cos/sin       : registered results (hold when res_valid is low)
//   idle              : no grant, nothing in flight, no result this cycle
//
// Pipeline alignment: an angle granted at edge E sits in cordic_angle after E,
// the engine captures it at E+1 and presents cos/sin after E+LAT. The issue
// tag register travels alongside cordic_angle, then LAT tag stages mirror the
// engine stages, so tag_q[LAT-1] is valid exactly when the engine output is,
// and the result register captures at E+LAT+1.
module cordic_rr_scheduler
  import cordic_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = cordic_pkg::CORDIC_WIDTH,
  parameter int AW    = cordic_pkg::ANGLE_W,
  parameter int LAT   = 16,
  parameter int XSEED = cordic_pkg::XSEED
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*AW-1:0]      req_angle,
  output logic [NREQ-1:0]         req_ready,
  output logic [WIDTH-1:0]        cordic_x,
  output logic [WIDTH-1:0]        cordic_y,
  output logic [AW-1:0]           cordic_angle,
  input  logic [WIDTH-1:0]        cordic_cos,
  input  logic [WIDTH-1:0]        cordic_sin,
  output logic                    res_valid,
  output logic [$clog2(NREQ)-1:0] res_id,
  output logic [WIDTH-1:0]        res_cos,
  output logic [WIDTH-1:0]        res_sin,
  output logic                    idle
);

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0] grant;
  logic            fire;
  logic [IDW-1:0]  grant_id;
  logic [AW-1:0]   grant_angle;
  tag_t            issue_tag;
  tag_t            tag_q [LAT];
  logic            any_tag;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .req   (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;
  assign fire      = |(req_valid & grant);
  assign cordic_x  = WIDTH'(XSEED);
  assign cordic_y  = '0;

  // Encode the one-hot grant and select the granted angle.
  always_comb begin
    grant_id    = '0;
    grant_angle = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grant_id    = IDW'(i);
        grant_angle = req_angle[i*AW +: AW];
      end
    end
  end

  // Issue register: the angle holds when nothing is granted, the tag does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cordic_angle <= '0;
      issue_tag    <= '0;
    end else begin
      if (fire) begin
        cordic_angle <= grant_angle;
        issue_tag    <= '{v: 1'b1, id: ID_W'(grant_id)};
      end else begin
        issue_tag    <= '0;
      end
    end
  end

  // NOTE: the tag array is reset on purpose: its valid bits decide whether
  // a result is produced, so stale entries after reset would emit phantom
  // results. Arrays holding pure data need no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      tag_q[0] <= issue_tag;
      for (int k = 1; k < LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  // Result register: capture when the tag emerging beside the engine is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_cos   <= '0;
      res_sin   <= '0;
    end else begin
      res_valid <= tag_q[LAT-1].v;
      if (tag_q[LAT-1].v) begin
        res_id  <= tag_q[LAT-1].id[IDW-1:0];
        res_cos <= cordic_cos;
        res_sin <= cordic_sin;
      end
    end
  end

  always_comb begin
    any_tag = issue_tag.v;
    for (int k = 0; k < LAT; k++) begin
      any_tag = any_tag | tag_q[k].v;
    end
  end

  assign idle = ~|req_ready & ~any_tag & ~res_valid;

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Self-checking bench for cordic_rr_scheduler. A behavioural LAT-stage
// CORDIC stand-in feeds the DUT; expected results (hand-computed cos/sin,
// requester id, arrival cycle) are queued at issue time and a negedge
// monitor pops and compares each res_valid.
module tb_cordic_rr_scheduler;
  import cordic_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int AW    = 32;
  localparam int LAT   = 16;
  localparam int TOL   = 8;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    en = 1'b0;
  logic [NREQ-1:0]         req_valid = '0;
  logic [NREQ*AW-1:0]      req_angle = '0;
  logic [NREQ-1:0]         req_ready;
  logic [WIDTH-1:0]        cordic_x;
  logic [WIDTH-1:0]        cordic_y;
  logic [AW-1:0]           cordic_angle;
  logic [WIDTH-1:0]        cordic_cos;
  logic [WIDTH-1:0]        cordic_sin;
  logic                    res_valid;
  logic [$clog2(NREQ)-1:0] res_id;
  logic [WIDTH-1:0]        res_cos;
  logic [WIDTH-1:0]        res_sin;
  logic                    idle;

  always #5 clk = ~clk;

  cordic_rr_scheduler #(
    .NREQ(NREQ), .WIDTH(WIDTH), .AW(AW), .LAT(LAT), .XSEED(19429)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .req_valid    (req_valid),
    .req_angle    (req_angle),
    .req_ready    (req_ready),
    .cordic_x     (cordic_x),
    .cordic_y     (cordic_y),
    .cordic_angle (cordic_angle),
    .cordic_cos   (cordic_cos),
    .cordic_sin   (cordic_sin),
    .res_valid    (res_valid),
    .res_id       (res_id),
    .res_cos      (res_cos),
    .res_sin      (res_sin),
    .idle         (idle)
  );

  // ---------------- engine stand-in: LAT register stages ----------------
  logic [AW-1:0] eng [LAT];
  initial for (int k = 0; k < LAT; k++) eng[k] = '0;

  always @(posedge clk) begin
    eng[0] <= cordic_angle;
    for (int k = 1; k < LAT; k++) eng[k] <= eng[k-1];
  end

  function automatic logic [WIDTH-1:0] eng_val(input logic [AW-1:0] a, input bit sine);
    real th;
    real r;
    th = (real'(a) / 4294967296.0) * 2.0 * 3.14159265358979;
    r  = 32000.0 * (sine ? $sin(th) : $cos(th));
    return WIDTH'(int'(r));
  endfunction

  assign cordic_cos = eng_val(eng[LAT-1], 1'b0);
  assign cordic_sin = eng_val(eng[LAT-1], 1'b1);

  // ---------------- checking infrastructure ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_tol(input string name, input int act, input int exp);
    int d;
    n_checks++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > TOL) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d +/-%0d (t=%0t)", name, act, exp, TOL, $time);
    end
  endtask

  // Hand-computed 32000*cos / 32000*sin for the angles used.
  function automatic int exp_cos(input logic [AW-1:0] a);
    case (a)
      32'h0:   return 32000;
      DEG45:   return 22627;
      DEG60:   return 16000;
      DEG75:   return 8282;
      DEG90:   return 0;
      default: return -1;
    endcase
  endfunction

  function automatic int exp_sin(input logic [AW-1:0] a);
    case (a)
      32'h0:   return 0;
      DEG45:   return 22627;
      DEG60:   return 27713;
      DEG75:   return 30910;
      DEG90:   return 32000;
      default: return -1;
    endcase
  endfunction

  typedef struct {
    int id;
    int c;
    int s;
    int due;
  } exp_t;

  exp_t sb[$];

  // Monitor: every res_valid must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (res_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_result_id", int'(res_id), -1);
      end else begin
        e = sb.pop_front();
        check("res_id", int'(res_id), e.id);
        check_tol("res_cos", int'(res_cos), e.c);
        check_tol("res_sin", int'(res_sin), e.s);
        check("res_cycle", cyc, e.due);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_angle(input int i, input logic [AW-1:0] a);
    req_angle[i*AW +: AW] = a;
  endtask

  // Drive one cycle: apply inputs at negedge, check the grant, queue the
  // expected result, then let the edge complete.
  task automatic step(input logic [NREQ-1:0] v, input logic e,
                      input logic [NREQ-1:0] exp_rdy, input bit push,
                      input string name);
    exp_t x;
    @(negedge clk);
    req_valid = v;
    en        = e;
    #1;
    check(name, int'(req_ready), int'(exp_rdy));
    if (push) begin
      for (int i = 0; i < NREQ; i++) begin
        if (exp_rdy[i]) begin
          x.id  = i;
          x.c   = exp_cos(req_angle[i*AW +: AW]);
          x.s   = exp_sin(req_angle[i*AW +: AW]);
          x.due = cyc + LAT + 2;
          sb.push_back(x);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 200 && sb.size() != 0; k++) begin
      @(negedge clk);
      #2;
    end
    check(name, sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int gcnt [NREQ];

  initial begin
    // ---- reset state (inputs active to prove req_ready is gated) ----
    rst_n     = 1'b0;
    en        = 1'b1;
    req_valid = '1;
    #12;
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_idle", int'(idle), 1);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_cordic_angle", int'(cordic_angle), 0);
    check("cordic_x", int'(cordic_x), 19429);
    check("cordic_y", int'(cordic_y), 0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // ---- single requester 0, DEG45 ----
    set_angle(0, DEG45);
    step(4'b0001, 1'b1, 4'b0001, 1'b1, "t1_grant");
    check("t1_cordic_angle", int'(cordic_angle), int'(DEG45));
    step(4'b0000, 1'b1, 4'b0000, 1'b0, "t1_release");
    check("t1_idle_busy", int'(idle), 0);
    wait_drain("t1_drain");

    // ---- requester 2: DEG60 then DEG90 back to back (ptr=1) ----
    set_angle(2, DEG60);
    step(4'b0100, 1'b1, 4'b0100, 1'b1, "t2_grant_a");
    set_angle(2, DEG90);
    step(4'b0100, 1'b1, 4'b0100, 1'b1, "t2_grant_b");
    step(4'b0000, 1'b1, 4'b0000, 1'b0, "t2_release");
    wait_drain("t2_drain");

    // ---- move ptr from 3 to 0 ----
    set_angle(3, 32'h0);
    step(4'b1000, 1'b1, 4'b1000, 1'b1, "align_grant");

    // ---- all four continuously valid for 16 cycles ----
    set_angle(0, 32'h0);
    set_angle(1, DEG45);
    set_angle(2, DEG60);
    set_angle(3, DEG90);
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    for (int k = 0; k < 16; k++) begin
      step(4'b1111, 1'b1, 4'(1 << (k % 4)), 1'b1, "t3_grant_order");
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) gcnt[i]++;
    end
    step(4'b0000, 1'b1, 4'b0000, 1'b0, "t3_release");
    for (int i = 0; i < NREQ; i++) check("t3_grant_count", gcnt[i], 4);
    wait_drain("t3_drain");

    // ---- ptr to 2, then 1 and 3 valid; en low for 5 cycles ----
    set_angle(1, DEG75);
    step(4'b0010, 1'b1, 4'b0010, 1'b1, "t4_setptr");
    set_angle(1, DEG45);
    set_angle(3, DEG60);
    step(4'b1010, 1'b1, 4'b1000, 1'b1, "t4_first_is_3");
    step(4'b1010, 1'b1, 4'b0010, 1'b1, "t4_then_1");
    for (int k = 0; k < 5; k++) begin
      step(4'b1010, 1'b0, 4'b0000, 1'b0, "t4_en_low_ready");
      if (k == 0) check("t4_idle_inflight", int'(idle), 0);
    end
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "t4_release");
    wait_drain("t4_drain");
    @(negedge clk);
    #1;
    check("t4_idle_after_drain", int'(idle), 1);

    // ---- reset 5 cycles after issuing DEG75; result must vanish ----
    set_angle(0, DEG75);
    step(4'b0001, 1'b1, 4'b0001, 1'b0, "t5_grant");
    for (int k = 0; k < 4; k++) step(4'b0000, 1'b1, 4'b0000, 1'b0, "t5_wait");
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 4'b0001;
    #1;
    check("t5_rst_req_ready", int'(req_ready), 0);
    check("t5_rst_res_valid", int'(res_valid), 0);
    check("t5_rst_idle", int'(idle), 1);
    check("t5_rst_cordic_angle", int'(cordic_angle), 0);
    check("t5_rst_res_id", int'(res_id), 0);
    check("t5_rst_res_cos", int'(res_cos), 0);
    check("t5_rst_res_sin", int'(res_sin), 0);
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;
    set_angle(1, DEG60);
    step(4'b0010, 1'b1, 4'b0010, 1'b1, "t5_post_reset_grant");
    step(4'b0000, 1'b1, 4'b0000, 1'b0, "t5_release");
    wait_drain("t5_drain");
    // Quiet window: any stray result is flagged by the monitor.
    repeat (LAT + 4) @(negedge clk);
    #1;
    check("final_idle", int'(idle), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_rr_scheduler.md
# cordic_rr_scheduler

Round-robin scheduler that shares one pipelined CORDIC sine/cosine engine among NREQ requesters. Each requester presents an angle with a valid/ready handshake. The scheduler issues at most one angle per clock into the engine, drives the engine's fixed X/Y seed, and tracks requester IDs through a tag pipeline matched to the engine latency. It returns each cos/sin result tagged with the originating requester's ID. It sits between client blocks (angle generators, test sequencers) and the single CORDIC instance.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 16, X/Y/cos/sin width
- AW, 32, angle width; full circle = 2^AW
- LAT, 16, CORDIC clocks from angle-input edge to valid cos/sin; must equal the engine instance depth
- XSEED, 19429, X seed = round(32000/1.647); Y seed is 0

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  issue enable; when low, no new grants are made and in-flight work still drains
- req_valid  in  NREQ  per-requester angle valid
- req_angle  in  NREQ*AW  packed angles; requester i occupies bits [i*AW +: AW]
- req_ready  out  NREQ  one-hot grant, combinational from req_valid, en and the pointer
- cordic_x  out  WIDTH  constant XSEED
- cordic_y  out  WIDTH  constant 0
- cordic_angle  out  AW  registered angle to the engine
- cordic_cos  in  WIDTH  engine cos output
- cordic_sin  in  WIDTH  engine sin output
- res_valid  out  1  result strobe, one cycle per issued angle
- res_id  out  clog2(NREQ)  requester ID of the result
- res_cos  out  WIDTH  registered cos
- res_sin  out  WIDTH  registered sin
- idle  out  1  no grant this cycle and no tag in flight

## Operation
- Arbitration:
  - Pointer ptr (reset 0).
  - The grant goes to the first i at or after ptr (wrapping) with req_valid[i]=1, but only when en=1.
  - On a grant to i, ptr becomes (i+1) mod NREQ at the next edge. With no grant, ptr holds.
- Issue:
  - On a handshake edge (req_valid[i] & req_ready[i]), cordic_angle takes req_angle[i].
  - Tag stage 0 takes {1, i}.
  - With no handshake, cordic_angle holds its value and tag stage 0 takes {0, x}.
- Tag pipeline: LAT stages of {v, id}, shifting every clock, with no stall.
- Result:
  - When tag stage LAT-1 has v=1, the next edge sets res_valid=1, res_id=id, and captures res_cos/res_sin from cordic_cos/cordic_sin.
  - Otherwise res_valid=0 and res_cos/res_sin hold.
- Results cannot be backpressured. Consumers filter on res_id and must sink one result per cycle.
- en falling mid-stream: grants stop at once. Already-issued tags still produce results.
- Requesters hold req_angle stable while req_valid=1 and not granted. Dropping req_valid without a grant is permitted.
- Reset values (async assert, sync deassert):
  - ptr=0, all tags v=0, cordic_angle=0.
  - res_valid=0, res_id=0, res_cos=0, res_sin=0.
  - idle=1, req_ready=0 while rst_n=0.
- Reset mid-operation: in-flight results are discarded, and no res_valid appears for angles issued before reset.

## Timing
- Throughput: one issue per clock, sustained.
- Latency: handshake at edge E → cordic_angle valid after E → res_valid high for one cycle after edge E+LAT+1.
- Fairness: a continuously valid requester is granted within NREQ cycles while en=1.
- Results emerge in issue order. Back-to-back issues yield back-to-back res_valid.
- idle = ~|req_ready & ~|tag_v[LAT-1:0] & ~res_valid.

## Structure
- Package cordic_pkg holds:
  - CORDIC_WIDTH=16, ANGLE_W=32, XSEED=19429
  - Angle constants: DEG45=32'h2000_0000, DEG60=32'h2AAA_AAAA, DEG75=32'h3555_5555, DEG90=32'h4000_0000
  - typedef tag_t {v, id}
- One sub-module, rr_arbiter: parameter N; inputs req, en, clk, rst_n; output one-hot grant; owns ptr.
- The top holds the issue register, the tag shift register and the result register. The CORDIC engine is instantiated beside it, not inside it.

## Test plan
All results use tolerance ±8 LSB against an engine with LAT=16.
- Single requester 0, angle DEG45 → one res_valid with res_id=0 and cos≈sin≈22627, exactly LAT+1 cycles after the handshake.
- Requester 2 issues DEG60, then DEG90, on consecutive cycles → res_id=2 on two consecutive cycles: (16000, 27713) then (≈0, 32000).
- All four requesters continuously valid with distinct angles for 16 cycles:
  - grant order is 0,1,2,3,0,…
  - each requester gets exactly 4 grants
  - 16 consecutive res_valid with matching res_id order.
- Requesters 1 and 3 valid, ptr=2 → first grant to 3, then 1. en dropped for 5 cycles → req_ready=0 throughout, results of prior issues still arrive, and idle rises after the drain.
- rst_n pulsed low 5 cycles after issuing DEG75 → all outputs reset immediately, no res_valid for that angle, and a new issue after release completes normally.
